clk_switch_ctrl: RTL
====================

// Module: clk_switch_ctrl
// PURPOSE
//  - Sequencer on the always-on clock that drives sel_clk1 of the glitch-free clock switch.
//  - Accepts valid/ready source-change requests and flips the select.
//  - Holds off further requests for SETTLE_CYC cycles, covering both domains' pos/neg sync chains.
//  - Pulses done once the new source is guaranteed on clk_out; keeps a completed-switch count.
// PARAMETERS
//  - SETTLE_CYC  16  cycles sel_clk1 is held stable after a change before done; must be >= 1
//  - DWELL_CYC   32  minimum cycles between completed switch and next accept (CLK_SW_DWELL_EN only); >= 1
//  - SW_CNT_W    8   width of saturating switch counter
// PORTS
//  - clk        in   1         single clock, all logic posedge
//  - rst        in   1         reset, synchronous, active-high
//  - req_valid  in   1         switch request valid
//  - req_sel    in   1         requested source: 1 = clk1, 0 = clk2
//  - req_ready  out  1         request accepted when req_valid & req_ready
//  - sel_clk1   out  1         registered select to clock switch (1 = clk1)
//  - cur_sel    out  1         committed source, updates only when done pulses
//  - busy       out  1         high in SWITCH (and DWELL) states
//  - done       out  1         one-cycle pulse: request fully completed
//  - sw_cnt     out  SW_CNT_W  completed real switches, saturates at all-ones
// BEHAVIOUR
//  - Reset values: sel_clk1=1, cur_sel=1, req_ready=1, busy=0, done=0, sw_cnt=0, state IDLE.
//  - Reset dominates everything, mid-operation included.
//  - req_ready = (state==IDLE), registered/decoded from state, never combinational from req_valid.
//  - States: IDLE, SWITCH, DWELL (DWELL exists only with CLK_SW_DWELL_EN).
//  - Accept at cycle N, req_sel != sel_clk1:
//    - N+1: sel_clk1 <= req_sel, state SWITCH, timer <= SETTLE_CYC-1, busy=1.
//    - SWITCH: timer decrements each cycle; when timer==0, next edge takes the exit below.
//    - N+SETTLE_CYC+1: done=1, cur_sel <= sel_clk1, sw_cnt+1 (saturating).
//    - Same edge: state -> IDLE, or -> DWELL if enabled.
//  - Accept at N, req_sel == sel_clk1: N+1 done=1, no sel change, sw_cnt unchanged, stay IDLE, no dwell.
//  - req_valid/req_sel while not ready: ignored, not queued. Requester holds valid until accepted.
//  - sel_clk1 never changes outside the accept edge; max one change per SETTLE_CYC+1 cycles.
//  - done is never high in two consecutive cycles unless back-to-back same-source requests.
//  - Counter arithmetic: timer width TW = $clog2(max(SETTLE_CYC,DWELL_CYC))+1, unsigned, no wrap.
// CONFIGURATION
//  - Macro CLK_SW_DWELL_EN defined:
//    - after a real switch's done edge, state DWELL, timer <= DWELL_CYC-1, busy=1, req_ready=0.
//    - IDLE again DWELL_CYC cycles after done; next accept earliest at N+SETTLE_CYC+DWELL_CYC+1.
//  - Undefined: no DWELL state or logic; req_ready=1 in the same cycle done pulses.
// STRUCTURE
//  - clk_sw_defs.vh: state encodings (IDLE=2'd0, SWITCH=2'd1, DWELL=2'd2), SEL_CLK1/SEL_CLK2 constants.
//  - One sub-module clk_sw_timer: loadable down-counter (load, load_val, dec, zero flag), TW-bit.
//    Shared by SWITCH and DWELL.
//  - Top: FSM, sel/cur_sel registers, sw_cnt saturating counter; all outputs registered.
// TESTING (SETTLE_CYC=16, DWELL_CYC=32, SW_CNT_W=8)
//  - Release rst, idle: sel_clk1=1, cur_sel=1, req_ready=1, busy=0, done=0, sw_cnt=0.
//  - Accept req_sel=0 at N -> sel_clk1=0 at N+1, busy N+1..N+16, done only at N+17, cur_sel=0, sw_cnt=1.
//  - Accept req_sel=1 while sel_clk1=1 -> done at N+1, sel_clk1 unchanged, sw_cnt unchanged, no busy.
//  - Hold req_valid with alternating req_sel during SWITCH -> req_ready=0, sel_clk1 steady until done.
//  - rst asserted at N+8 of a switch -> next cycle sel_clk1=1, IDLE, no done pulse, sw_cnt=0.
//  - CLK_SW_DWELL_EN: back-to-back opposite requests -> second accept at N+49, not before.
//    Undefined: accept at N+17. Also 255 switches -> sw_cnt holds 8'hFF.

Source files
------------

// File: rtl/clk_sw_pkg.sv
// Shared definitions for the clock-switch sequencer: state encodings and select constants.
package clk_sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_DWELL  = 2'd2
  } state_t;

  localparam logic SEL_CLK1 = 1'b1;
  localparam logic SEL_CLK2 = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_sw_timer.sv
// Loadable TW-bit down-counter with zero flag; shared by the settle and dwell phases.
module clk_sw_timer #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Always-on-clock sequencer driving sel_clk1 of a glitch-free clock switch.
// Define CLK_SW_DWELL_EN to add a post-switch DWELL hold-off phase.
module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DWELL_CYC  = 32,
  parameter int SW_CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_sel,
  output logic                req_ready,
  output logic                sel_clk1,
  output logic                cur_sel,
  output logic                busy,
  output logic                done,
  output logic [SW_CNT_W-1:0] sw_cnt
);

  localparam int TW = $clog2(max_int(SETTLE_CYC, DWELL_CYC)) + 1;
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYC - 1);
`ifdef CLK_SW_DWELL_EN
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYC - 1);
`endif

  state_t                r_state, w_state_nxt;
  logic                  r_sel, r_cur_sel, r_done;
  logic [SW_CNT_W-1:0]   r_sw_cnt;
  logic                  w_sel_nxt, w_done_nxt, w_commit;
  logic                  w_load, w_dec, w_tmr_zero;
  logic [TW-1:0]         w_load_val;

  clk_sw_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .zero     (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_done_nxt  = 1'b0;
    w_commit    = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_dec       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_sel != r_sel) begin
            w_sel_nxt   = req_sel;
            w_state_nxt = ST_SWITCH;
            w_load      = 1'b1;
            w_load_val  = SETTLE_LOAD;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      ST_SWITCH: begin
        if (w_tmr_zero) begin
          w_done_nxt = 1'b1;
          w_commit   = 1'b1;
`ifdef CLK_SW_DWELL_EN
          w_state_nxt = ST_DWELL;
          w_load      = 1'b1;
          w_load_val  = DWELL_LOAD;
`else
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_dec = 1'b1;
        end
      end
`ifdef CLK_SW_DWELL_EN
      ST_DWELL: begin
        if (w_tmr_zero) w_state_nxt = ST_IDLE;
        else            w_dec = 1'b1;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // cur_sel and the count only move on the completion edge of a real switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= SEL_CLK1;
      r_cur_sel <= SEL_CLK1;
      r_done    <= 1'b0;
      r_sw_cnt  <= '0;
    end else begin
      r_sel  <= w_sel_nxt;
      r_done <= w_done_nxt;
      if (w_commit) begin
        r_cur_sel <= r_sel;
        if (r_sw_cnt != '1) r_sw_cnt <= r_sw_cnt + 1'b1;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign sel_clk1  = r_sel;
  assign cur_sel   = r_cur_sel;
  assign done      = r_done;
  assign sw_cnt    = r_sw_cnt;

endmodule
